ahb_flash_reader_qspi: RTL
==========================

Name: ahb_flash_reader_qspi

Overview:
- AHB-Lite read-only slave that fetches 32-bit words from external QSPI NOR flash using a hardware sequencer.
- Issues Fast Read Quad I/O (EBh) per word and stalls the bus via HREADYOUT until the word is assembled.
- Drives the fr_* flash-reader pins, which the flash writer's mux passes to the device when its write-enable is clear.

Parameters:
- ADDR_WIDTH, 24: flash byte-address bits sent on the bus (24 only; other values unsupported).
- DUMMY_CYCLES, 4: SCK periods of dummy after the mode byte.
- MODE_BYTE, 8'hFF: mode bits sent after the address; the default avoids entering continuous-read mode.

Ports:
- HCLK  input  1  clock; SCK = HCLK/2.
- HRESET  input  1  asynchronous, active-high reset.
- HSEL  input  1  slave select.
- HADDR  input  32  address; [23:2] used.
- HTRANS  input  2  transfer type.
- HWRITE  input  1  write flag; writes are ignored.
- HREADY  input  1  bus ready.
- HWDATA  input  32  unused.
- HSIZE  input  3  unused; the full word is always returned.
- HREADYOUT  output  1  low while a fetch is in progress.
- HRDATA  output  32  read data.
- fr_sck  output  1  flash clock, idle low (SPI mode 0).
- fr_ce_n  output  1  flash chip select, active low.
- fr_dout  output  4  IO[3:0] out.
- fr_douten  output  1  common output enable for IO[3:0].
- fr_din  input  4  IO[3:0] in.

Behaviour:
- Reset values: HREADYOUT=1, HRDATA=0, fr_sck=0, fr_ce_n=1, fr_dout=4'b1100, fr_douten=0. Reset takes effect immediately, even mid-fetch; the FSM returns to IDLE.
- Accept condition: HSEL & HREADY & HTRANS[1] & ~HWRITE. Flash address = {HADDR[23:2],2'b00}.
- Writes, IDLE and BUSY transfers, and unselected cycles: no flash activity, HREADYOUT=1.
- FSM states: IDLE, CSH, CMD, ADDR, MODE, DUMMY, DATA, DONE.
- SCK timing in active states:
  - fr_sck toggles every HCLK.
  - fr_dout changes only on the HCLK edge that drives fr_sck low.
  - fr_din is sampled on the HCLK edge that drives fr_sck high.
- CMD: 8 SCK periods. EBh is sent MSB first on IO0; IO[3:2]=2'b11 (WP#/HOLD# high); IO1=0; douten=1.
- ADDR: 6 SCK periods, one nibble per period, MSB first; douten=1.
- MODE: 2 SCK periods sending MODE_BYTE, high nibble first; douten=1.
- DUMMY: DUMMY_CYCLES periods; douten=0.
- DATA: 8 periods capturing nibbles in order byte0 hi, byte0 lo, byte1 hi, … byte3 lo.
  - Byte assembly: byte at A+n goes to HRDATA[8n+7:8n] (little-endian).
- Data-phase timing (default parameters):
  - Accept at edge 0.
  - fr_ce_n low from cycle 1 through cycle 56, i.e. 28 SCK periods.
  - Cycle 57 is DONE: fr_ce_n=1, fr_sck=0, HREADYOUT=1, HRDATA valid.
  - HREADYOUT is low exactly 56 cycles.
- HRDATA holds its value until the next fetch completes.
- Back-to-back: a read accepted during DONE goes to CSH (one cycle, ce_n=1, HREADYOUT=0) and then CMD. fr_ce_n high time is therefore always at least 2 HCLK.
- Only one fetch is in flight at a time. Bit/nibble counters are 4 bits and wrap only at state change.

Optional Feature:
- Macro: AHB_FLASH_READER_BUF_EN.
- Enabled: adds a one-word buffer (valid bit, tag = HADDR[23:2], data).
  - A read whose tag matches a valid entry completes with zero wait states: HREADYOUT stays 1 and HRDATA = buffer data in the data phase.
  - A miss performs a normal fetch and refills the buffer in DONE.
  - Reset clears the valid bit.
- Disabled: every read fetches from flash.

Decomposition:
- Package flash_reader_pkg holds:
  - state enum;
  - CMD_QUAD_IO_READ=8'hEB;
  - CMD_CYCLES=8, ADDR_CYCLES=6, MODE_CYCLES=2, DATA_CYCLES=8.
- Sub-module flash_qspi_seq: takes start + address and returns done + data, driving the fr_* pins. The top keeps only the AHB handshake and the optional buffer.

Test Plan:
- Reset: assert HRESET mid-DATA -> fr_ce_n=1, fr_sck=0, fr_douten=0 and HREADYOUT=1 in the same cycle; the next read restarts from CMD.
- Single read: HADDR=0x00000104, flash bytes 11 22 33 44 at 0x104 -> HRDATA=0x44332211 after 56 wait cycles; IO0 shows EBh; address nibbles 0,0,0,1,0,4; mode nibbles F,F.
- Sub-word read: HSIZE=byte, HADDR=0x106 -> flash address 0x104, full word 0x44332211 returned.
- Back-to-back: read 0x100 then 0x104 with the second accepted during DONE -> fr_ce_n high exactly 2 cycles between fetches; both words correct.
- Write to 0x100 with HWDATA=0xDEADBEEF -> HREADYOUT stays 1, fr_ce_n stays 1, the next read is unaffected.
- With AHB_FLASH_READER_BUF_EN: two reads of 0x200 -> first takes 56 wait cycles, second takes 0 with identical data. A read of 0x204 then misses and refetches.

Source files
------------

// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the QSPI flash reader (Fast Read Quad I/O, EBh).
package flash_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSH,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [7:0]  CMD_QUAD_IO_READ = 8'hEB;
    localparam int unsigned CMD_CYCLES       = 8;
    localparam int unsigned ADDR_CYCLES      = 6;
    localparam int unsigned MODE_CYCLES      = 2;
    localparam int unsigned DATA_CYCLES      = 8;
    localparam int unsigned FLASH_AW         = 24;
    // WP#/HOLD# high, IO1/IO0 low whenever the bus is not carrying a phase
    localparam logic [3:0]  DOUT_IDLE        = 4'b1100;

    function automatic state_t next_phase(input state_t s);
        case (s)
            ST_CMD:   return ST_ADDR;
            ST_ADDR:  return ST_MODE;
            ST_MODE:  return ST_DUMMY;
            ST_DUMMY: return ST_DATA;
            default:  return ST_DONE;
        endcase
    endfunction

endpackage

// File: rtl/ahb_flash_reader_qspi_seq.sv
// flash_qspi_seq: one EBh word fetch per start; SCK = clk/2, dout moves on SCK fall, din sampled on SCK rise.
module flash_qspi_seq
    import flash_reader_pkg::*;
#(
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter logic [7:0]  MODE_BYTE    = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [FLASH_AW-1:0] i_addr,
    input  logic [3:0]          i_din,
    output logic                o_done_c,
    output logic [31:0]         o_data,
    output logic                o_sck,
    output logic                o_ce_n,
    output logic [3:0]          o_dout,
    output logic                o_douten
);

    state_t              r_state, w_state_nx, w_phase_nx;
    logic [3:0]          r_cnt, w_cnt_nx;
    logic                r_sck, w_sck_nx;
    logic                r_ce_n, w_ce_n_nx;
    logic [3:0]          r_dout, w_dout_nx;
    logic                r_douten, w_douten_nx;
    logic [FLASH_AW-1:0] r_addr, w_addr_nx;
    logic [31:0]         r_data, w_data_nx;

    function automatic logic [3:0] last_cnt(input state_t s);
        case (s)
            ST_CMD:   return 4'(CMD_CYCLES - 1);
            ST_ADDR:  return 4'(ADDR_CYCLES - 1);
            ST_MODE:  return 4'(MODE_CYCLES - 1);
            ST_DUMMY: return 4'(DUMMY_CYCLES - 1);
            default:  return 4'(DATA_CYCLES - 1);
        endcase
    endfunction

    // Nibble presented on IO[3:0] during period c of phase s
    function automatic logic [3:0] period_nibble(input state_t s, input logic [3:0] c,
                                                 input logic [FLASH_AW-1:0] a);
        case (s)
            ST_CMD:  return {2'b11, 1'b0, CMD_QUAD_IO_READ[3'(4'd7 - c)]};
            ST_ADDR: return 4'(a >> (5'd20 - 5'(c) * 5'd4));
            ST_MODE: return (c == 4'd0) ? MODE_BYTE[7:4] : MODE_BYTE[3:0];
            default: return DOUT_IDLE;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_sck    <= 1'b0;
            r_ce_n   <= 1'b1;
            r_dout   <= DOUT_IDLE;
            r_douten <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_sck    <= w_sck_nx;
            r_ce_n   <= w_ce_n_nx;
            r_dout   <= w_dout_nx;
            r_douten <= w_douten_nx;
            r_addr   <= w_addr_nx;
            r_data   <= w_data_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_phase_nx  = next_phase(r_state);
        w_cnt_nx    = r_cnt;
        w_sck_nx    = r_sck;
        w_ce_n_nx   = r_ce_n;
        w_dout_nx   = r_dout;
        w_douten_nx = r_douten;
        w_addr_nx   = r_addr;
        w_data_nx   = r_data;
        o_done_c    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nx  = ST_IDLE;
                w_sck_nx    = 1'b0;
                w_ce_n_nx   = 1'b1;
                w_douten_nx = 1'b0;
                w_dout_nx   = DOUT_IDLE;
                if (i_start) begin
                    w_addr_nx = i_addr;
                    // Straight out of a fetch, hold CE# high one more cycle first
                    if (r_state == ST_DONE) begin
                        w_state_nx = ST_CSH;
                    end else begin
                        w_state_nx  = ST_CMD;
                        w_cnt_nx    = 4'd0;
                        w_ce_n_nx   = 1'b0;
                        w_douten_nx = 1'b1;
                        w_dout_nx   = period_nibble(ST_CMD, 4'd0, i_addr);
                    end
                end
            end
            ST_CSH: begin
                w_state_nx  = ST_CMD;
                w_cnt_nx    = 4'd0;
                w_ce_n_nx   = 1'b0;
                w_douten_nx = 1'b1;
                w_dout_nx   = period_nibble(ST_CMD, 4'd0, r_addr);
            end
            default: begin
                w_sck_nx = ~r_sck;
                if (!r_sck) begin
                    if (r_state == ST_DATA)
                        w_data_nx[{r_cnt[2:1], ~r_cnt[0], 2'b00} +: 4] = i_din;
                end else if (r_cnt != last_cnt(r_state)) begin
                    w_cnt_nx  = r_cnt + 4'd1;
                    w_dout_nx = period_nibble(r_state, r_cnt + 4'd1, r_addr);
                end else if (r_state == ST_DATA) begin
                    o_done_c    = 1'b1;
                    w_state_nx  = ST_DONE;
                    w_ce_n_nx   = 1'b1;
                    w_douten_nx = 1'b0;
                    w_dout_nx   = DOUT_IDLE;
                end else begin
                    w_state_nx  = w_phase_nx;
                    w_cnt_nx    = 4'd0;
                    w_dout_nx   = period_nibble(w_phase_nx, 4'd0, r_addr);
                    w_douten_nx = (w_phase_nx == ST_ADDR) || (w_phase_nx == ST_MODE);
                end
            end
        endcase
    end

    assign o_data   = r_data;
    assign o_sck    = r_sck;
    assign o_ce_n   = r_ce_n;
    assign o_dout   = r_dout;
    assign o_douten = r_douten;

endmodule

// File: rtl/ahb_flash_reader_qspi.sv
// AHB-Lite read-only slave returning 32-bit words from QSPI NOR flash.
// Optional one-word read buffer: define AHB_FLASH_READER_BUF_EN.
module ahb_flash_reader_qspi
    import flash_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter logic [7:0]  MODE_BYTE    = 8'hFF
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        fr_sck,
    output logic        fr_ce_n,
    output logic [3:0]  fr_dout,
    output logic        fr_douten,
    input  logic [3:0]  fr_din
);

    localparam int unsigned TAG_W = ADDR_WIDTH - 2;

    logic        w_accept, w_hit, w_start, w_done;
    logic [31:0] w_data, w_buf_data;
    logic        r_hreadyout;
    logic [31:0] r_hrdata;
    logic        w_unused;

    assign w_unused = ^{HWDATA, HSIZE, HADDR[31:ADDR_WIDTH], HADDR[1:0], HTRANS[0]};
    assign w_accept = HSEL & HREADY & HTRANS[1] & ~HWRITE & r_hreadyout;
    assign w_start  = w_accept & ~w_hit;

`ifdef AHB_FLASH_READER_BUF_EN
    logic [TAG_W-1:0] w_tag, r_buf_tag, r_fetch_tag;
    logic             r_buf_valid;
    logic [31:0]      r_buf_data;

    assign w_tag      = HADDR[ADDR_WIDTH-1:2];
    assign w_hit      = r_buf_valid && (r_buf_tag == w_tag);
    assign w_buf_data = r_buf_data;

    // Buffer refills with the word of every completed fetch
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_fetch_tag <= '0;
            r_buf_data  <= '0;
        end else begin
            if (w_start)
                r_fetch_tag <= w_tag;
            if (w_done) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= r_fetch_tag;
                r_buf_data  <= w_data;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = 32'd0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_hreadyout <= 1'b1;
            r_hrdata    <= 32'd0;
        end else if (w_done) begin
            r_hreadyout <= 1'b1;
            r_hrdata    <= w_data;
        end else if (w_start) begin
            r_hreadyout <= 1'b0;
        end else if (w_accept) begin
            r_hrdata    <= w_buf_data;
        end
    end

    flash_qspi_seq #(
        .DUMMY_CYCLES (DUMMY_CYCLES),
        .MODE_BYTE    (MODE_BYTE)
    ) u_seq (
        .clk      (HCLK),
        .rst      (HRESET),
        .i_start  (w_start),
        .i_addr   ({HADDR[ADDR_WIDTH-1:2], 2'b00}),
        .i_din    (fr_din),
        .o_done_c (w_done),
        .o_data   (w_data),
        .o_sck    (fr_sck),
        .o_ce_n   (fr_ce_n),
        .o_dout   (fr_dout),
        .o_douten (fr_douten)
    );

    assign HREADYOUT = r_hreadyout;
    assign HRDATA    = r_hrdata;

endmodule
